// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader sequencer: FSM state encoding and
// the error codes reported on err_code.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

endpackage

// File: rtl/boot_wdog.sv
// Watchdog for the RUN phase: a loadable down-counter that stops at zero and
// flags expiry while it sits there.
module boot_wdog #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Count down from the loaded value while enabled; hold at zero once reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot loader sequencer: streams program words into external memory while
// holding the CPU in reset, then releases the CPU and watches for the halt PC
// or a watchdog timeout.
// Optional feature macro: BOOT_CHECKSUM_EN adds a running 32-bit checksum of
// every written word on the checksum output.
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          MAX_WORDS   = 256,
    parameter logic [31:0] HALT_PC     = 32'h13C,
    parameter int          WDOG_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    input  logic [31:0] cpu_pc,
    output logic        cpu_reset,
    output logic        Ext_MemWrite,
    output logic [31:0] Ext_DataAdr,
    output logic [31:0] Ext_WriteData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] word_count
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [31:0] checksum
`endif
);

    localparam int WDOG_W = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LOAD = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t state;
    logic   last_taken;
    logic   start_accept;
    logic   wdog_expired;

    assign start_accept = start &&
                          ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));

    boot_wdog #(
        .WIDTH(WDOG_W)
    ) u_wdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_accept),
        .load      ((state == ST_LOAD) && last_taken),
        .load_value(WDOG_LOAD),
        .enable    (state == ST_RUN),
        .expired   (wdog_expired)
    );

    // Main sequencer: owns the write port, CPU reset and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            last_taken    <= 1'b0;
            cpu_reset     <= 1'b1;
            Ext_MemWrite  <= 1'b0;
            Ext_DataAdr   <= BASE_ADDR;
            Ext_WriteData <= 32'h0;
            ld_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            word_count    <= 16'h0;
        end else begin
            Ext_MemWrite <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        last_taken <= 1'b0;
                        ld_ready   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        err_code   <= ERR_NONE;
                        word_count <= 16'h0;
                    end
                end
                ST_LOAD: begin
                    if (last_taken) begin
                        state      <= ST_RUN;
                        last_taken <= 1'b0;
                        cpu_reset  <= 1'b0;
                    end else if (ld_valid && ld_ready) begin
                        if (word_count == MAX_COUNT) begin
                            state    <= ST_ERROR;
                            ld_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            err_code <= ERR_OVF;
                        end else begin
                            Ext_MemWrite  <= 1'b1;
                            Ext_DataAdr   <= BASE_ADDR + 32'({word_count, 2'b00});
                            Ext_WriteData <= ld_data;
                            word_count    <= word_count + 16'd1;
                            if (ld_last) begin
                                ld_ready   <= 1'b0;
                                last_taken <= 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_pc == HALT_PC) begin
                        state     <= ST_DONE;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (wdog_expired) begin
                        state     <= ST_ERROR;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_code  <= ERR_TMO;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic write_accept;

    assign write_accept = (state == ST_LOAD) && !last_taken && ld_valid && ld_ready &&
                          (word_count != MAX_COUNT);

    // Wraparound sum of every word actually written during the current load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= 32'h0;
        end else if (start_accept) begin
            checksum <= 32'h0;
        end else if (write_accept) begin
            checksum <= checksum + ld_data;
        end
    end
`endif

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: table-driven load/overflow vectors
// plus hand-written sequences for halt, throttling, watchdog, tie and reset.
module tb_boot_load_ctrl;

    localparam logic [31:0] BASE    = 32'h0;
    localparam int          MAXW    = 4;
    localparam logic [31:0] HALT    = 32'h13C;
    localparam int          WDOG    = 32;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic [31:0] cpu_pc;
    logic        cpu_reset;
    logic        Ext_MemWrite;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_WriteData;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic [15:0] word_count;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic        last;
        logic [31:0] data;
        logic        rdy;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [15:0] wc;
        logic        crst;
        logic        busy;
        logic        err;
        logic [1:0]  code;
    } vec_t;

    vec_t load_vecs[$];
    vec_t ovf_vecs[$];

    boot_load_ctrl #(
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (MAXW),
        .HALT_PC    (HALT),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .cpu_pc       (cpu_pc),
        .cpu_reset    (cpu_reset),
        .Ext_MemWrite (Ext_MemWrite),
        .Ext_DataAdr  (Ext_DataAdr),
        .Ext_WriteData(Ext_WriteData),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .word_count   (word_count)
`ifdef BOOT_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic v, input logic l, input logic [31:0] d,
                                input logic rdy, input logic mw, input logic [31:0] adr,
                                input logic [31:0] wd, input logic [15:0] wc, input logic crst,
                                input logic bsy, input logic err, input logic [1:0] code);
        vec_t r;
        r.start = s;   r.valid = v;  r.last = l;   r.data = d;
        r.rdy = rdy;   r.mw = mw;    r.adr = adr;  r.wdata = wd;
        r.wc = wc;     r.crst = crst; r.busy = bsy; r.err = err; r.code = code;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        start    = v.start;
        ld_valid = v.valid;
        ld_last  = v.last;
        ld_data  = v.data;
    endtask

    task automatic check_output(input string tag, input vec_t v);
        check({tag, ".ld_ready"},   ld_ready,      v.rdy);
        check({tag, ".memwrite"},   Ext_MemWrite,  v.mw);
        check({tag, ".adr"},        Ext_DataAdr,   v.adr);
        check({tag, ".wdata"},      Ext_WriteData, v.wdata);
        check({tag, ".word_count"}, word_count,    v.wc);
        check({tag, ".cpu_reset"},  cpu_reset,     v.crst);
        check({tag, ".busy"},       busy,          v.busy);
        check({tag, ".error"},      error,         v.err);
        check({tag, ".err_code"},   err_code,      v.code);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ld_ready"},   ld_ready,      1'b0);
        check({tag, ".memwrite"},   Ext_MemWrite,  1'b0);
        check({tag, ".adr"},        Ext_DataAdr,   BASE);
        check({tag, ".wdata"},      Ext_WriteData, 32'h0);
        check({tag, ".word_count"}, word_count,    16'h0);
        check({tag, ".cpu_reset"},  cpu_reset,     1'b1);
        check({tag, ".busy"},       busy,          1'b0);
        check({tag, ".done"},       done,          1'b0);
        check({tag, ".error"},      error,         1'b0);
        check({tag, ".err_code"},   err_code,      2'd0);
    endtask

    initial begin
        int run_bad;
        int n;

        // Four-word load ending in RUN.
        load_vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0,        0, 1, 1, 0, 0));
        load_vecs.push_back(mk(0, 1, 0, 32'h00500093, 1, 1, 32'h0, 32'h00500093, 1, 1, 1, 0, 0));
        load_vecs.push_back(mk(0, 1, 0, 32'h00100113, 1, 1, 32'h4, 32'h00100113, 2, 1, 1, 0, 0));
        load_vecs.push_back(mk(0, 1, 0, 32'hAAAA5555, 1, 1, 32'h8, 32'hAAAA5555, 3, 1, 1, 0, 0));
        load_vecs.push_back(mk(0, 1, 1, 32'h12345678, 0, 1, 32'hC, 32'h12345678, 4, 1, 1, 0, 0));
        load_vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'hC, 32'h12345678, 4, 0, 1, 0, 0));

        // Five words into a four-word limit; previous write was 0x0BADF00D at 0x0.
        ovf_vecs.push_back(mk(1, 0, 0, 32'h0,        1, 0, 32'h0, 32'h0BADF00D, 0, 1, 1, 0, 0));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h11111111, 1, 1, 32'h0, 32'h11111111, 1, 1, 1, 0, 0));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h22222222, 1, 1, 32'h4, 32'h22222222, 2, 1, 1, 0, 0));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h33333333, 1, 1, 32'h8, 32'h33333333, 3, 1, 1, 0, 0));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h44444444, 1, 1, 32'hC, 32'h44444444, 4, 1, 1, 0, 0));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h55555555, 0, 0, 32'hC, 32'h44444444, 4, 1, 0, 1, 1));
        ovf_vecs.push_back(mk(0, 1, 0, 32'h66666666, 0, 0, 32'hC, 32'h44444444, 4, 1, 0, 1, 1));

        reset = 1'b0; start = 0; ld_valid = 0; ld_last = 0; ld_data = 0; cpu_pc = 0;
        repeat (3) tick();
        check_reset_values("rst_held");
        reset = 1'b1;
        tick();
        check_reset_values("rst_idle");

        $display("[TB] four-word load");
        for (int i = 0; i < load_vecs.size(); i++) begin
            apply_stimulus(load_vecs[i]);
            tick();
            check_output($sformatf("load%0d", i), load_vecs[i]);
        end

        // RUN until PC hits halt at RUN cycle 20; a stray start in RUN is ignored.
        run_bad = 0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 5);
            tick();
            if (cpu_reset !== 1'b0 || Ext_MemWrite !== 1'b0) run_bad++;
        end
        start = 0;
        check("halt.run_cycles", run_bad, 0);
        cpu_pc = HALT;
        tick();
        cpu_pc = 0;
        check("halt.done", done, 1'b1);
        check("halt.cpu_reset", cpu_reset, 1'b1);
        check("halt.busy", busy, 1'b0);
        check("halt.error", error, 1'b0);
        check("halt.word_count", word_count, 16'd4);

        $display("[TB] throttled load");
        start = 1; tick(); start = 0;
        check("thr.done_cleared", done, 1'b0);
        n = 0;
        run_bad = 0;
        for (int i = 0; i < 9; i++) begin
            ld_valid = (i % 3 == 2);
            ld_last  = (i == 8);
            ld_data  = 32'hC0DE0000 + i;
            tick();
            if (Ext_MemWrite !== ld_valid) run_bad++;
            if (ld_valid) begin
                check($sformatf("thr%0d.adr", i), Ext_DataAdr, BASE + 32'(4 * n));
                check($sformatf("thr%0d.wdata", i), Ext_WriteData, 32'hC0DE0000 + i);
                n++;
                check($sformatf("thr%0d.wc", i), word_count, 16'(n));
            end
        end
        check("thr.pulse_pattern", run_bad, 0);
        ld_valid = 0; ld_last = 0;

        // Never halt: exactly WDOG RUN cycles, then timeout.
        run_bad = 0;
        for (int k = 0; k < WDOG; k++) begin
            tick();
            if (cpu_reset !== 1'b0 || error !== 1'b0) run_bad++;
        end
        check("wdog.run_cycles", run_bad, 0);
        tick();
        check("wdog.error", error, 1'b1);
        check("wdog.err_code", err_code, 2'd2);
        check("wdog.cpu_reset", cpu_reset, 1'b1);
        check("wdog.busy", busy, 1'b0);
        check("wdog.done", done, 1'b0);

        // Halt on the same cycle the watchdog expires: halt wins.
        start = 1; tick(); start = 0;
        check("tie.err_cleared", error, 1'b0);
        check("tie.code_cleared", err_code, 2'd0);
        ld_valid = 1; ld_last = 1; ld_data = 32'h0BADF00D;
        tick();
        ld_valid = 0; ld_last = 0;
        check("tie.write", Ext_MemWrite, 1'b1);
        for (int k = 0; k < WDOG; k++) tick();
        cpu_pc = HALT;
        tick();
        cpu_pc = 0;
        check("tie.done", done, 1'b1);
        check("tie.error", error, 1'b0);
        check("tie.err_code", err_code, 2'd0);

        $display("[TB] overflow");
        for (int i = 0; i < ovf_vecs.size(); i++) begin
            apply_stimulus(ovf_vecs[i]);
            tick();
            check_output($sformatf("ovf%0d", i), ovf_vecs[i]);
        end
        ld_valid = 0;

        $display("[TB] reset mid-load");
        start = 1; tick(); start = 0;
        ld_valid = 1; ld_data = 32'h1; tick();
        ld_data = 32'h2; tick();
        check("mid.wc_before", word_count, 16'd2);
        ld_data = 32'hFFFFFFFF;
        #1 reset = 1'b0;
        #1 check_reset_values("mid_async");
        tick();
        check("mid.no_write", Ext_MemWrite, 1'b0);
        check("mid.wc_held", word_count, 16'd0);
        reset = 1'b1; ld_valid = 0;
        start = 1; tick(); start = 0;
        check("reload.ready", ld_ready, 1'b1);
        ld_valid = 1; ld_data = 32'h1; tick();
        check("reload0.adr", Ext_DataAdr, BASE);
        ld_data = 32'h2; tick();
        check("reload1.adr", Ext_DataAdr, BASE + 32'h4);
        ld_data = 32'hFFFFFFFF; ld_last = 1; tick();
        check("reload2.adr", Ext_DataAdr, BASE + 32'h8);
        check("reload2.wc", word_count, 16'd3);
        ld_valid = 0; ld_last = 0;
        tick();
        check("reload.run", cpu_reset, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        check("reload.checksum", checksum, 32'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_load_ctrl.md
Name: boot_load_ctrl

Overview:
Sequencer that owns the CPU's external memory write port and the CPU reset during boot. It accepts a stream of 32-bit program words over a valid/ready handshake and writes them to consecutive word addresses from BASE_ADDR through the Ext_MemWrite/Ext_DataAdr/Ext_WriteData port, holding the CPU in reset. After the last word it releases the CPU and monitors PC for a halt address or a watchdog timeout. It sits between the host/test harness and riscv_cpu_main.

Parameters:
BASE_ADDR, 32'h0, byte address of first loaded word
MAX_WORDS, 256, maximum words accepted per load (overflow = error)
HALT_PC, 32'h13C, PC value that signals program completion
WDOG_CYCLES, 4096, max RUN cycles before timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a load from IDLE/DONE/ERROR
ld_valid  in  1  program word valid
ld_ready  out  1  block can accept a word
ld_data  in  32  program word
ld_last  in  1  marks final word of the program
cpu_pc  in  32  PC from CPU
cpu_reset  out  1  active-high reset to CPU
Ext_MemWrite  out  1  external memory write strobe
Ext_DataAdr  out  32  external write byte address
Ext_WriteData  out  32  external write data
busy  out  1  high in LOAD or RUN
done  out  1  sticky; halt PC reached
error  out  1  sticky; overflow or watchdog
err_code  out  2  0 none, 1 overflow, 2 timeout
word_count  out  16  words written in current load

Behaviour:
- Reset (reset=0, async): state IDLE; cpu_reset=1; Ext_MemWrite=0; Ext_DataAdr=BASE_ADDR; Ext_WriteData=0; ld_ready=0; busy/done/error=0; err_code=0; word_count=0; watchdog=0.
- States: IDLE, LOAD, RUN, DONE, ERROR. cpu_reset=1 in every state except RUN.
- IDLE/DONE/ERROR --start--> LOAD: clear done, error, err_code, word_count; next address = BASE_ADDR.
- LOAD: ld_ready=1. Transfer when ld_valid && ld_ready. Outputs are registered: the cycle after a transfer, Ext_MemWrite=1 for exactly one cycle with Ext_DataAdr = BASE_ADDR + 4*word_count(old) and Ext_WriteData = ld_data; word_count increments with the write. Back-to-back transfers give back-to-back writes.
- Overflow: a transfer while word_count == MAX_WORDS is not written; go to ERROR, err_code=1.
- Transfer with ld_last=1: the write is issued, ld_ready drops next cycle, and the state goes to RUN one cycle after the write (cpu_reset deasserts then).
- RUN: cpu_reset=0; Ext_MemWrite=0; watchdog increments each cycle.
  - cpu_pc == HALT_PC -> DONE (done=1), cpu_reset=1 next cycle.
  - watchdog reaches WDOG_CYCLES-1 without halt -> ERROR, err_code=2.
  - If both occur in the same cycle, halt wins.
- start outside IDLE/DONE/ERROR is ignored.
- Async reset during LOAD or RUN: immediately returns to reset values; no partial write is generated after reset rises.
- ld_ready=0 outside LOAD; ld_valid is ignored there.
- Address arithmetic is modulo 2^32.

Optional Feature:
BOOT_CHECKSUM_EN:
- Defined: adds output checksum[31:0], a running 32-bit wraparound sum of every written word, cleared on start/reset and frozen after LOAD.
- Not defined: the port is absent and no adder is built.

Decomposition:
- Package boot_pkg holds the state encoding (IDLE/LOAD/RUN/DONE/ERROR) and the err_code constants (ERR_NONE, ERR_OVF, ERR_TMO).
- One natural sub-module, boot_wdog: a loadable down-counter with enable, clear and expired outputs.
- The FSM and write-port register stay in the top module.

Test Plan:
- Load 4 words (0x00500093, 0x00100113, 0xAAAA5555, 0x12345678), the last with ld_last -> writes at 0x0, 0x4, 0x8, 0xC with matching data; word_count=4; cpu_reset falls 1 cycle after the last write.
- Throttled ld_valid (valid every 3rd cycle) -> Ext_MemWrite pulses exactly 1 cycle each; addresses stay contiguous.
- In RUN, drive cpu_pc to 0x13C at cycle 20 -> done=1, cpu_reset=1, busy=0 next cycle; error=0.
- With WDOG_CYCLES=16, never reach HALT_PC -> ERROR after 16 RUN cycles, err_code=2, cpu_reset=1.
- With MAX_WORDS=2, send 3 words -> only 2 writes; ERROR, err_code=1, no write to 0x8.
- Assert reset low mid-LOAD after 2 writes -> all outputs return to reset values at once; a new start reloads from BASE_ADDR. With BOOT_CHECKSUM_EN, words 1, 2, 0xFFFFFFFF give checksum=2.
